// File: rtl/stat_display_pkg.sv
// Shared constants for stat_display: select codes, digit count, seven-segment glyphs
// and the serial binary-to-BCD converter's state encoding.
package stat_display_pkg;

  localparam logic [2:0] SEL_TOTAL   = 3'd0;
  localparam logic [2:0] SEL_COND    = 3'd1;
  localparam logic [2:0] SEL_UNCOND  = 3'd2;
  localparam logic [2:0] SEL_COND_OK = 3'd3;

  localparam int unsigned NUM_DIGITS = 8;

  // Active-low g..a patterns, entry 15 first so SEG_GLYPH[n] is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bcd_state_e;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [31:0] bcd_adjust(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: 32-bit binary in, low 8 packed BCD digits out
// (value mod 10^8). One shift per cycle; done is high for the single cycle in StDone.
module bin2bcd_serial
  import stat_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd
);

  bcd_state_e  state_q;
  logic [31:0] bin_q;
  logic [31:0] bcd_q;
  logic [4:0]  cnt_q;
  logic [31:0] bcd_adj;

  // Digits above the eighth fall off the top; carries only move upward, so the low
  // eight digits stay exact.
  always_comb bcd_adj = bcd_adjust(bcd_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bin_q   <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign bcd  = bcd_q;

endmodule

// File: rtl/stat_display.sv
// Scans a frame-consistent snapshot of one CPU statistics counter onto an 8-digit
// active-low seven-segment display. Define STAT_DISPLAY_BCD_EN to show decimal.
module stat_display
  import stat_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic        freeze,
  input  logic [31:0] total,
  input  logic [31:0] conditional,
  input  logic [31:0] unconditional,
  input  logic [31:0] conditional_success,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [31:0] shown_value
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DivW-1:0]       div_q;
  logic [2:0]            idx_q;
  logic [31:0]           snapshot_q, snapshot_d;
  logic [NUM_DIGITS-1:0] an_q;
  logic [7:0]            seg_q;
  logic                  tick, frame_end;
  logic [31:0]           selected;
  logic [3:0]            nibble;
  logic                  dp_n;

  assign tick      = (div_q == DivW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx_q == 3'd7);

  always_comb begin
    selected = '0;
    case (sel)
      SEL_TOTAL:   selected = total;
      SEL_COND:    selected = conditional;
      SEL_UNCOND:  selected = unconditional;
      SEL_COND_OK: selected = conditional_success;
      default:     selected = '0;
    endcase
  end

`ifdef STAT_DISPLAY_BCD_EN
  logic        conv_busy, conv_done;
  logic [31:0] conv_bcd;

  bin2bcd_serial u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (frame_end && !freeze && !conv_busy),
    .bin   (selected),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    snapshot_d = snapshot_q;
    if (conv_done) snapshot_d = conv_bcd;
  end
`else
  always_comb begin
    snapshot_d = snapshot_q;
    if (frame_end && !freeze) snapshot_d = selected;
  end
`endif

  assign nibble = snapshot_q[{idx_q, 2'b00} +: 4];
  // Decimal point marks the digit whose position equals the active select code.
  assign dp_n   = !((sel < 3'd4) && (idx_q == {1'b0, sel[1:0]}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      snapshot_q <= '0;
      an_q       <= '1;
      seg_q      <= '1;
    end else begin
      div_q      <= tick ? '0 : div_q + DivW'(1);
      idx_q      <= tick ? idx_q + 3'd1 : idx_q;
      snapshot_q <= snapshot_d;
      an_q       <= ~(8'b1 << idx_q);
      seg_q      <= {dp_n, SEG_GLYPH[nibble]};
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign shown_value = snapshot_q;

endmodule

// File: tb/tb_stat_display.sv
// Directed bench for stat_display with SCAN_DIV=8 (64-cycle frames).
module tb_stat_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic        freeze;
  logic [31:0] total, conditional, unconditional, conditional_success;
  logic [7:0]  an, seg;
  logic [31:0] shown_value;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit inc_total = 1'b0;
  logic [7:0] exp_seg1 [8];

  stat_display #(.SCAN_DIV(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sel                 (sel),
    .freeze              (freeze),
    .total               (total),
    .conditional         (conditional),
    .unconditional       (unconditional),
    .conditional_success (conditional_success),
    .an                  (an),
    .seg                 (seg),
    .shown_value         (shown_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance n rising edges, leaving the bench 1 time unit past the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inc_total) total = total + 32'd1;
    end
  endtask

  task automatic step_to(input int t);
    step(t - cyc);
  endtask

  initial begin
    exp_seg1 = '{8'h00, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    rst = 1'b0;
    sel = 3'd0;
    freeze = 1'b0;
    total = 32'h1234_5678;
    conditional = 32'h0;
    unconditional = 32'h0;
    conditional_success = 32'h0;
    #12;
    rst = 1'b1;
    cyc = 0;
    check("reset_an", {24'h0, an}, 32'hFF);
    check("reset_seg", {24'h0, seg}, 32'hFF);
    check("reset_shown", shown_value, 32'h0);

`ifndef STAT_DISPLAY_BCD_EN
    // Scan order and first-frame contents (snapshot still zero).
    step_to(1);
    check("first_an", {24'h0, an}, 32'hFE);
    check("first_seg_dp", {24'h0, seg}, 32'h40);
    step_to(9);
    check("digit1_an", {24'h0, an}, 32'hFD);
    check("digit1_seg", {24'h0, seg}, 32'hC0);
    step_to(63);
    check("pre_frame_shown", shown_value, 32'h0);
    step_to(64);
    check("frame_load", shown_value, 32'h1234_5678);
    check("last_digit_an", {24'h0, an}, 32'h7F);
    for (int d = 0; d < 8; d++) begin
      step_to(65 + 8 * d);
      check($sformatf("hex_an%0d", d), {24'h0, an}, {24'h0, ~(8'b1 << d)});
      check($sformatf("hex_seg%0d", d), {24'h0, seg}, {24'h0, exp_seg1[d]});
    end

    // Select change mid-frame waits for frame_end; dp follows sel immediately.
    sel = 3'd3;
    conditional_success = 32'h0000_ABCD;
    conditional = 32'h0000_0042;
    step_to(128);
    check("sel3_load", shown_value, 32'h0000_ABCD);
    step_to(129);
    check("sel3_seg0", {24'h0, seg}, 32'hA1);
    step_to(148);
    sel = 3'd1;
    step_to(153);
    check("sel_switch_seg3", {24'h0, seg}, 32'h88);
    step_to(191);
    check("sel_switch_hold", shown_value, 32'h0000_ABCD);
    step_to(192);
    check("sel1_load", shown_value, 32'h0000_0042);
    step_to(193);
    check("sel1_seg0", {24'h0, seg}, 32'hA4);
    step_to(201);
    check("sel1_an1", {24'h0, an}, 32'hFD);
    check("sel1_seg1_dp", {24'h0, seg}, 32'h19);

    // Freeze holds the snapshot across frames while the counter runs.
    sel = 3'd0;
    freeze = 1'b1;
    total = 32'h1000_0000;
    inc_total = 1'b1;
    step_to(256);
    check("freeze_f1", shown_value, 32'h0000_0042);
    step_to(320);
    check("freeze_f2", shown_value, 32'h0000_0042);
    step_to(384);
    check("freeze_f3", shown_value, 32'h0000_0042);
    freeze = 1'b0;
    step_to(447);
    check("unfreeze_wait", shown_value, 32'h0000_0042);
    step_to(448);
    check("unfreeze_load", shown_value, 32'h1000_00F6);
    inc_total = 1'b0;

    // Invalid select loads zero and never lights dp.
    sel = 3'd5;
    step_to(512);
    check("invalid_load", shown_value, 32'h0);
    for (int d = 0; d < 3; d++) begin
      step_to(513 + 8 * d);
      check($sformatf("invalid_seg%0d", d), {24'h0, seg}, 32'hC0);
    end

    // Asynchronous reset mid-frame, no clock edge needed.
    step_to(542);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_an", {24'h0, an}, 32'hFF);
    check("async_rst_seg", {24'h0, seg}, 32'hFF);
    check("async_rst_shown", shown_value, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    cyc = 0;
    step_to(1);
    check("restart_an", {24'h0, an}, 32'hFE);
    check("restart_seg", {24'h0, seg}, 32'hC0);
    step_to(9);
    check("restart_an1", {24'h0, an}, 32'hFD);

    // Plain binary 123456789 in hex mode.
    sel = 3'd0;
    total = 32'd123456789;
    step_to(64);
    check("hex_dec_load", shown_value, 32'h075B_CD15);
    step_to(65);
    check("hex_dec_seg0", {24'h0, seg}, 32'h12);
`else
    // Decimal conversion: previous value shown until the converter finishes.
    total = 32'd123456789;
    step_to(1);
    check("first_an", {24'h0, an}, 32'hFE);
    step_to(96);
    check("bcd_busy_hold", shown_value, 32'h0);
    step_to(98);
    check("bcd_load", shown_value, 32'h2345_6789);
    step_to(129);
    check("bcd_seg0", {24'h0, seg}, 32'h10);
    check("bcd_an0", {24'h0, an}, 32'hFE);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stat_display.md
Name: stat_display

Overview:
- Downstream consumer of the single-cycle CPU's run-statistics counter block on the FPGA board.
- Takes the four 32-bit statistics counters (total cycles, conditional branches, unconditional jumps, taken conditional branches).
- Selects one counter and latches a frame-consistent snapshot.
- Drives an 8-digit multiplexed, active-low seven-segment display with it.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays lit. Minimum 2; 8 in simulation.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- sel  input  3  counter select: 0 total, 1 conditional, 2 unconditional, 3 conditional_success, 4-7 invalid
- freeze  input  1  1 = hold current snapshot and ignore counter changes
- total  input  32  total-cycle counter
- conditional  input  32  conditional-branch counter
- unconditional  input  32  unconditional-jump counter
- conditional_success  input  32  taken-conditional counter
- an  output  8  digit enables, active-low; bit i = digit i, digit 0 rightmost
- seg  output  8  cathodes, active-low; [6:0] = g..a, [7] = dp
- shown_value  output  32  snapshot currently displayed (binary, or packed BCD under the option)

Behaviour:
- Reset (rst=0, asynchronous): div=0, idx=0, snapshot=0, an=8'hFF, seg=8'hFF, shown_value=0.
- Divider: div counts 0..SCAN_DIV-1 and wraps. tick = (div==SCAN_DIV-1).
- Digit index: idx (3 bits) increments on tick and wraps 7->0. frame_end = tick && idx==7.
- Snapshot, hex mode:
  - On frame_end with freeze=0: snapshot <= selected counter; invalid sel loads 0.
  - With freeze=1 the snapshot holds.
  - A sel change mid-frame takes effect only at the next frame_end.
  - shown_value = snapshot.
- Outputs are registered, 1-cycle latency from idx/snapshot.
  - an = ~(8'b1 << idx).
  - seg[6:0] = hex glyph of snapshot[4*idx+3 : 4*idx]. Glyphs (g..a active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - seg[7] = 0 (dp lit) iff sel<4 and idx==sel[1:0], marking which counter is shown. Otherwise 1.
- First cycle after reset release: an=FE, seg=C0 (digit 0, value 0, dp off since idx0==sel only if sel=0 -> then seg=40).
- No leading-zero blanking. All 8 digits are always scanned.
- Reset asserted mid-frame returns everything to reset values immediately.

Optional Feature:
- Macro: STAT_DISPLAY_BCD_EN.
- Defined:
  - On frame_end with freeze=0, a serial double-dabble conversion of the selected counter starts.
  - FSM: IDLE -> SHIFT (32 cycles, add-3 on nibbles >=5 then shift) -> DONE (1 cycle).
  - In DONE, snapshot <= low 8 BCD digits, i.e. value mod 10^8.
  - The previous snapshot stays displayed during conversion.
  - frame_end arriving while not IDLE is ignored.
  - Requires 8*SCAN_DIV >= 40.
  - Glyphs A-F never appear.
- Undefined: hex mode as above. The converter is not instantiated.

Decomposition:
- Package stat_display_pkg holds:
  - sel code constants SEL_TOTAL=0, SEL_COND=1, SEL_UNCOND=2, SEL_COND_OK=3;
  - NUM_DIGITS=8;
  - the 16-entry seven-segment glyph constant table;
  - BCD FSM state encodings IDLE/SHIFT/DONE.
- One natural sub-module: bin2bcd_serial (32-bit in, start/done handshake, 32-bit packed BCD out), instantiated only under STAT_DISPLAY_BCD_EN.

Test Plan (SCAN_DIV=8, frame = 64 cycles):
- Reset release, sel=0, total=0x12345678 -> an=FE then FD... every 8 cycles. After the first frame_end (cycle 64), the next frame shows digits 8,7,6,5,4,3,2,1 on an FE..7F. dp is lit only on digit 0.
- sel=3, conditional_success=0x0000ABCD, switch sel to 1 at cycle 20 of a frame -> the old value persists until frame_end, then the new counter's value is shown. dp moves to digit 1.
- freeze=1 while total increments every cycle -> shown_value constant across 3 frames. Drop freeze -> the value updates at the next frame_end.
- sel=5 -> shown_value=0, all digits show C0 (dp off).
- rst pulsed low at cycle 30 of a frame -> an=FF, seg=FF, shown_value=0 in the same cycle, with no clock edge needed. Scanning restarts at digit 0.
- BCD_EN, total=123456789 -> after frame_end + 34 cycles, shown_value=0x23456789. Display reads 23456789.
